acq_scheduler: RTL and testbench

ACQ_SCHEDULER -- requirements
Module: acq_scheduler

---
 rtl/acq_scheduler.sv | 149 ++++++++++++++
 tb/tb_acq_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_scheduler.sv
// Round-robin acquisition scheduler: drains per-channel FWFT sample queues into tagged byte packets.
// Optional checksum trailer is enabled by defining ACQ_SCHEDULER_CHECKSUM_EN.
module acq_scheduler #(
  parameter int NCH = 5,
  parameter int DW  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    en_mask,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    em,
  output logic [NCH-1:0]    pp,
  input  logic              full_write,
  output logic [7:0]        out_write,
  output logic              ld_write,
  output logic              busy,
  output logic [15:0]       pkt_cnt
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);
  localparam logic [CW:0]   NCH_W   = (CW + 1)'(NCH);
  localparam bit HAS_HI = (DW > 8);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3
`ifdef ACQ_SCHEDULER_CHECKSUM_EN
    ,
    CSUM    = 3'd4
`endif
  } state_t;

  state_t        state;
  logic [CW-1:0] ptr;
  logic [CW-1:0] ch_q;
  logic [DW-1:0] sample_q;
  logic [15:0]   cnt_q;

  logic [NCH-1:0] cand;
  logic           found;
  logic [CW-1:0]  gnt;
  logic [CW:0]    sum;
  logic [DW-1:0]  sel_sample;
  logic [7:0]     hdr_byte;
  logic [7:0]     hi_byte;
  logic [7:0]     lo_byte;

  assign cand    = en_mask & ~em;
  assign pkt_cnt = cnt_q;

  // Scan from ptr upward, wrapping at NCH; the first candidate met wins.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    sum   = '0;
    for (int k = 0; k < NCH; k++) begin
      sum = {1'b0, ptr} + (CW + 1)'(k);
      if (sum >= NCH_W) sum = sum - NCH_W;
      if (!found && cand[sum[CW-1:0]]) begin
        found = 1'b1;
        gnt   = sum[CW-1:0];
      end
    end
  end

  always_comb begin
    sel_sample = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt == CW'(k)) sel_sample = in_data[k*DW +: DW];
    end
  end

  assign hdr_byte = {3'(ch_q) + 3'd1, 5'b00000};
  assign hi_byte  = 8'(sample_q >> 8);
  assign lo_byte  = 8'(sample_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      ch_q      <= '0;
      sample_q  <= '0;
      cnt_q     <= '0;
      pp        <= '0;
      ld_write  <= 1'b0;
      out_write <= 8'h00;
      busy      <= 1'b0;
    end else begin
      pp       <= '0;
      ld_write <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            sample_q <= sel_sample;
            ch_q     <= gnt;
            pp       <= NCH'(1) << gnt;
            busy     <= 1'b1;
            ptr      <= (gnt == LAST_CH) ? '0 : gnt + CW'(1);
            state    <= HDR;
          end
        end
        HDR: begin
          if (!full_write) begin
            out_write <= hdr_byte;
            ld_write  <= 1'b1;
            state     <= HAS_HI ? DATA_HI : DATA_LO;
          end
        end
        DATA_HI: begin
          if (!full_write) begin
            out_write <= hi_byte;
            ld_write  <= 1'b1;
            state     <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (!full_write) begin
            out_write <= lo_byte;
            ld_write  <= 1'b1;
`ifdef ACQ_SCHEDULER_CHECKSUM_EN
            state     <= CSUM;
`else
            state     <= IDLE;
            busy      <= 1'b0;
            cnt_q     <= cnt_q + 16'd1;
`endif
          end
        end
`ifdef ACQ_SCHEDULER_CHECKSUM_EN
        CSUM: begin
          // hi_byte is zero when DW<=8, so it drops out of the XOR naturally.
          if (!full_write) begin
            out_write <= hdr_byte ^ hi_byte ^ lo_byte;
            ld_write  <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            cnt_q     <= cnt_q + 16'd1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_scheduler.sv
// Self-checking bench for acq_scheduler: main instance NCH=5/DW=12, second instance NCH=7/DW=8.
module tb_acq_scheduler;
  localparam int NCH  = 5;
  localparam int DW   = 12;
  localparam int NCH2 = 7;
  localparam int DW2  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;

  logic [NCH-1:0]    en_mask;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    em;
  logic [NCH-1:0]    pp;
  logic              full_write;
  logic [7:0]        out_write;
  logic              ld_write;
  logic              busy;
  logic [15:0]       pkt_cnt;

  logic [NCH2-1:0]     en_mask2;
  logic [NCH2*DW2-1:0] in_data2;
  logic [NCH2-1:0]     em2;
  logic [NCH2-1:0]     pp2;
  logic                full_write2;
  logic [7:0]          out_write2;
  logic                ld_write2;
  logic                busy2;
  logic [15:0]         pkt_cnt2;

  acq_scheduler #(.NCH(NCH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en_mask(en_mask), .in_data(in_data), .em(em), .pp(pp),
    .full_write(full_write), .out_write(out_write), .ld_write(ld_write), .busy(busy),
    .pkt_cnt(pkt_cnt)
  );

  acq_scheduler #(.NCH(NCH2), .DW(DW2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en_mask(en_mask2), .in_data(in_data2), .em(em2), .pp(pp2),
    .full_write(full_write2), .out_write(out_write2), .ld_write(ld_write2), .busy(busy2),
    .pkt_cnt(pkt_cnt2)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0]    exp_q[$];
  logic [7:0]    exp_q2[$];
  logic [DW-1:0] chq[NCH][$];
  int            pop_cnt[NCH];
  int            pop6_cnt;

  function automatic void refresh();
    for (int i = 0; i < NCH; i++) begin
      em[i] = (chq[i].size() == 0);
      in_data[i*DW +: DW] = (chq[i].size() != 0) ? chq[i][0] : '0;
    end
  endfunction

  function automatic void push_pkt(input int ch, input logic [DW-1:0] s);
    logic [7:0] h;
    logic [7:0] hi;
    logic [7:0] lo;
    h  = {3'(ch + 1), 5'b00000};
    hi = 8'(s >> 8);
    lo = s[7:0];
    exp_q.push_back(h);
    exp_q.push_back(hi);
    exp_q.push_back(lo);
`ifdef ACQ_SCHEDULER_CHECKSUM_EN
    exp_q.push_back(h ^ hi ^ lo);
`endif
  endfunction

  function automatic void load(input int ch, input logic [DW-1:0] s);
    chq[ch].push_back(s);
    push_pkt(ch, s);
    refresh();
  endfunction

  // Queue model and output scoreboards; outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        if (pp[i]) begin
          pop_cnt[i]++;
          if (chq[i].size() != 0) void'(chq[i].pop_front());
        end
      end
      refresh();
      if (ld_write) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte_stream: got %02h, required no byte", out_write);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (out_write !== e) begin
            errors++;
            $display("FAIL byte_stream: got %02h, required %02h", out_write, e);
          end
        end
      end
      if (pp2[6]) begin
        pop6_cnt++;
        em2[6] = 1'b1;
      end
      if (ld_write2) begin
        checks++;
        if (exp_q2.size() == 0) begin
          errors++;
          $display("FAIL byte_stream2: got %02h, required no byte", out_write2);
        end else begin
          logic [7:0] e;
          e = exp_q2.pop_front();
          if (out_write2 !== e) begin
            errors++;
            $display("FAIL byte_stream2: got %02h, required %02h", out_write2, e);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n      = 1'b0;
    full_write = 1'b0;
    en_mask    = '1;
    for (int i = 0; i < NCH; i++) begin
      chq[i].delete();
      pop_cnt[i] = 0;
    end
    exp_q.delete();
    refresh();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      #1;
      done = (exp_q.size() == 0) && !busy;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: got %0d bytes pending busy=%0b, required 0 pending busy=0",
               name, exp_q.size(), busy);
    end
  endtask

  task automatic wait_pending(input string name, input int target, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      #1;
      done = (exp_q.size() == target);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_wait: got %0d bytes pending, required %0d", name, exp_q.size(), target);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (pp !== '0 || ld_write !== 1'b0 || out_write !== 8'h00 || busy !== 1'b0 || pkt_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL %s: got pp=%h ld=%b out=%h busy=%b cnt=%h, required all zero",
               name, pp, ld_write, out_write, busy, pkt_cnt);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_outputs");
    checks++;
    if (pp2 !== '0 || ld_write2 !== 1'b0 || busy2 !== 1'b0 || pkt_cnt2 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs2: got pp=%h ld=%b busy=%b cnt=%h, required all zero",
               pp2, ld_write2, busy2, pkt_cnt2);
    end
  endtask

  task automatic test_basic();
    do_reset();
    load(1, 12'hABC);
    wait_idle("basic", 40);
    checks++;
    if (pop_cnt[1] !== 1 || pop_cnt[0] !== 0 || pop_cnt[2] !== 0) begin
      errors++;
      $display("FAIL basic_pop: got pp1 cycles=%0d pp0=%0d pp2=%0d, required 1,0,0",
               pop_cnt[1], pop_cnt[0], pop_cnt[2]);
    end
    checks++;
    if (pkt_cnt !== 16'd1) begin
      errors++;
      $display("FAIL basic_pkt_cnt: got %0d, required 1", pkt_cnt);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NCH; i++) load(i, DW'($urandom_range(0, 4095)));
    load(0, DW'($urandom_range(0, 4095)));
    wait_idle("round_robin", 200);
    checks++;
    if (pkt_cnt !== 16'd6 || pop_cnt[0] !== 2) begin
      errors++;
      $display("FAIL rr_counts: got pkt_cnt=%0d pp0 cycles=%0d, required 6 and 2", pkt_cnt, pop_cnt[0]);
    end
  endtask

  task automatic test_full_stall();
    int n;
    do_reset();
    load(0, 12'h123);
    n = exp_q.size();
    wait_pending("stall_hdr", n - 1, 30);
    full_write = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ld_write !== 1'b0) begin
        errors++;
        $display("FAIL stall_ld_write: got %b in stall cycle %0d, required 0", ld_write, k);
      end
    end
    full_write = 1'b0;
    wait_idle("stall", 40);
  endtask

  task automatic test_mask();
    do_reset();
    en_mask = 5'h02;
    chq[0].push_back(12'h111);
    load(1, 12'h2F0);
    wait_idle("mask", 40);
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (pop_cnt[0] !== 0 || pop_cnt[1] !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mask_pop: got pp0=%0d pp1=%0d busy=%b, required 0,1,0", pop_cnt[0], pop_cnt[1], busy);
    end
  endtask

  task automatic test_mask_change();
    int n;
    do_reset();
    load(3, 12'h5E1);
    n = exp_q.size();
    wait_pending("mchg_hdr", n - 1, 30);
    en_mask = '0;
    wait_idle("mask_change", 40);
    checks++;
    if (pkt_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mask_change_cnt: got %0d, required 1", pkt_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    load(4, 12'h9C7);
    n = exp_q.size();
    wait_pending("rst_mid", n - 2, 30);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_mid_outputs");
    exp_q.delete();
    for (int i = 0; i < NCH; i++) chq[i].delete();
    refresh();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    load(2, 12'h456);
    wait_idle("after_reset", 40);
    checks++;
    if (pkt_cnt !== 16'd1) begin
      errors++;
      $display("FAIL after_reset_cnt: got %0d, required 1", pkt_cnt);
    end
  endtask

  task automatic test_wrap();
    bit done;
    do_reset();
    pop6_cnt = 0;
    exp_q2.delete();
    force dut2.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut2.cnt_q;
    #1;
    in_data2[6*DW2 +: DW2] = 8'h5A;
    em2[6] = 1'b0;
    exp_q2.push_back(8'hE0);
    exp_q2.push_back(8'h5A);
`ifdef ACQ_SCHEDULER_CHECKSUM_EN
    exp_q2.push_back(8'hBA);
`endif
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      #1;
      done = (exp_q2.size() == 0) && !busy2;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wrap_timeout: got %0d bytes pending, required 0", exp_q2.size());
    end
    checks++;
    if (pkt_cnt2 !== 16'h0000 || pop6_cnt !== 1) begin
      errors++;
      $display("FAIL wrap_cnt: got pkt_cnt=%h pp6 cycles=%0d, required 0000 and 1", pkt_cnt2, pop6_cnt);
    end
  endtask

  initial begin
    full_write  = 1'b0;
    en_mask     = '1;
    en_mask2    = '1;
    em2         = '1;
    in_data2    = '0;
    full_write2 = 1'b0;
    pop6_cnt    = 0;
    for (int i = 0; i < NCH; i++) pop_cnt[i] = 0;
    refresh();
    test_reset();
    test_basic();
    test_round_robin();
    test_full_stall();
    test_mask();
    test_mask_change();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
